// File: rtl/pe_axi_pkg.sv
// Shared AXI widths, response codes and arbiter state encoding
// for the PE AXI read arbiter slice.
package pe_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pe_ord_fifo.sv
// Order FIFO recording which requester owns each outstanding burst.
// Push is refused when full and pop when empty.
module pe_ord_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pe_axi_rd_arbiter.sv
// Two-requester round-robin AR arbiter with in-order R routing
// onto a single PE AXI4 master read port.
module pe_axi_rd_arbiter
  import pe_axi_pkg::*;
#(
  parameter int ORDER_DEPTH = 8,
  parameter int NREQ        = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ*ADDR_W-1:0]      u_araddr,
  input  logic [NREQ*LEN_W-1:0]       u_arlen,
  input  logic [NREQ-1:0]             u_arvalid,
  output logic [NREQ-1:0]             u_arready,
  output logic [DATA_W-1:0]           u_rdata,
  output logic [RESP_W-1:0]           u_rresp,
  output logic                        u_rlast,
  output logic [NREQ-1:0]             u_rvalid,
  input  logic [NREQ-1:0]             u_rready,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [LEN_W-1:0]            m_arlen,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [RESP_W-1:0]           m_rresp,
  input  logic                        m_rlast,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  output logic [$clog2(ORDER_DEPTH):0] outstanding,
  output logic                        rd_err
);

  arb_state_e r_state;
  logic       r_prio;
  logic       r_grant;
  logic       r_rd_err;
  logic       w_grant;
  logic       w_ar_hs;
  logic       w_pop;
  logic       w_head;
  logic       w_full;
  logic       w_empty;

  // Grant is frozen while an AR waits on m_arready.
  always_comb begin
    w_grant = r_prio;
    if (r_state == ARB_HOLD)
      w_grant = r_grant;
    else if (!u_arvalid[r_prio] && u_arvalid[~r_prio])
      w_grant = ~r_prio;
  end

  assign m_arvalid = u_arvalid[w_grant] & ~w_full;
  assign m_araddr  = w_grant ? u_araddr[ADDR_W +: ADDR_W]
                             : u_araddr[0 +: ADDR_W];
  assign m_arlen   = w_grant ? u_arlen[LEN_W +: LEN_W]
                             : u_arlen[0 +: LEN_W];
  assign w_ar_hs   = m_arvalid & m_arready;

  always_comb begin
    u_arready          = '0;
    u_arready[w_grant] = m_arready & ~w_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_prio  <= 1'b0;
      r_grant <= 1'b0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (m_arvalid && !m_arready) begin
            r_state <= ARB_HOLD;
            r_grant <= w_grant;
          end
        end
        ARB_HOLD: begin
          if (w_ar_hs) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (w_ar_hs) r_prio <= ~w_grant;
    end
  end

  pe_ord_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (1)
  ) u_ord (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ar_hs),
    .i_din   (w_grant),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding)
  );

  assign m_rready = u_rready[w_head] & ~w_empty;
  assign w_pop    = m_rvalid & m_rready & m_rlast;
  assign u_rdata  = m_rdata;
  assign u_rresp  = m_rresp;
  assign u_rlast  = m_rlast;

  always_comb begin
    u_rvalid         = '0;
    u_rvalid[w_head] = m_rvalid & ~w_empty;
  end

  // A beat with no owner is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_err <= 1'b0;
    else if (m_rvalid && w_empty)
      r_rd_err <= 1'b1;
  end

  assign rd_err = r_rd_err;

endmodule

// File: tb/tb_pe_axi_rd_arbiter.sv
// Directed bench for pe_axi_rd_arbiter: arbitration, hold,
// ordering, full FIFO, orphan beats and async reset.
module tb_pe_axi_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [63:0] u_araddr;
  logic [15:0] u_arlen;
  logic [1:0]  u_arvalid;
  logic [1:0]  u_arready;
  logic [31:0] u_rdata;
  logic [1:0]  u_rresp;
  logic        u_rlast;
  logic [1:0]  u_rvalid;
  logic [1:0]  u_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [3:0]  outstanding;
  logic        rd_err;

  int n_chk;
  int n_err;

  pe_axi_rd_arbiter #(.ORDER_DEPTH(8), .NREQ(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .u_araddr    (u_araddr),
    .u_arlen     (u_arlen),
    .u_arvalid   (u_arvalid),
    .u_arready   (u_arready),
    .u_rdata     (u_rdata),
    .u_rresp     (u_rresp),
    .u_rlast     (u_rlast),
    .u_rvalid    (u_rvalid),
    .u_rready    (u_rready),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .outstanding (outstanding),
    .rd_err      (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    u_araddr  = '0;
    u_arlen   = '0;
    u_arvalid = '0;
    u_rready  = '0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_in();

    // Reset values
    #3;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_arready", u_arready, 0);
    chk("rst_rvalid", u_rvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_outst", outstanding, 0);
    chk("rst_err", rd_err, 0);
    do_reset();

    // Alternating grants with both requesters valid
    u_araddr  = {32'h2000, 32'h1000};
    u_arvalid = 2'b11;
    m_arready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_addr", m_araddr, (i % 2) ? 32'h2000 : 32'h1000);
      chk("rr_ardy", u_arready, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end
    chk("rr_outst", outstanding, 4);

    // Hold while master stalls
    do_reset();
    u_araddr  = {32'h0, 32'h3000};
    u_arlen   = {8'h0, 8'h3};
    u_arvalid = 2'b01;
    #1;
    chk("hold_vld", m_arvalid, 1);
    chk("hold_len", m_arlen, 3);
    tick();
    u_araddr  = {32'h4000, 32'h3000};
    u_arvalid = 2'b11;
    #1;
    chk("hold_a1", m_araddr, 32'h3000);
    tick();
    chk("hold_a2", m_araddr, 32'h3000);
    m_arready = 1'b1;
    #1;
    chk("hold_a3", m_araddr, 32'h3000);
    chk("hold_rdy", u_arready, 2'b01);
    tick();
    chk("hold_next", m_araddr, 32'h4000);
    chk("hold_rdy1", u_arready, 2'b10);

    // In-order R routing: req1 burst first, then req0
    do_reset();
    u_araddr  = {32'h5000, 32'h6000};
    u_arlen   = {8'h3, 8'h1};
    u_arvalid = 2'b10;
    m_arready = 1'b1;
    tick();
    u_arvalid = 2'b01;
    tick();
    u_arvalid = 2'b00;
    m_arready = 1'b0;
    #1;
    chk("ord_outst", outstanding, 2);
    u_rready = 2'b01;
    m_rvalid = 1'b1;
    m_rdata  = 32'hA0;
    #1;
    chk("ord_gate", m_rready, 0);
    u_rready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      m_rdata = 32'hA0 + k;
      m_rlast = (k == 3) || (k == 5);
      #1;
      chk("ord_rvld", u_rvalid, (k < 4) ? 2'b10 : 2'b01);
      chk("ord_data", u_rdata, 32'hA0 + k);
      chk("ord_rrdy", m_rready, 1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    chk("ord_done", outstanding, 0);
    chk("ord_noerr", rd_err, 0);

    // Order FIFO full
    do_reset();
    u_arvalid = 2'b01;
    m_arready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("full_outst", outstanding, 8);
    chk("full_arvld", m_arvalid, 0);
    chk("full_ardy", u_arready, 0);
    u_rready = 2'b11;
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    #1;
    chk("full_pop_blk", m_arvalid, 0);
    chk("full_rrdy", m_rready, 1);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    chk("full_7", outstanding, 7);
    chk("full_reopen", m_arvalid, 1);
    tick();
    chk("full_8", outstanding, 8);

    // Beat with nothing outstanding
    do_reset();
    u_rready = 2'b11;
    m_rvalid = 1'b1;
    #1;
    chk("err_rrdy", m_rready, 0);
    chk("err_rvld", u_rvalid, 0);
    tick();
    chk("err_set", rd_err, 1);
    m_rvalid = 1'b0;
    tick();
    tick();
    chk("err_sticky", rd_err, 1);
    do_reset();
    chk("err_clr", rd_err, 0);

    // Async reset mid-burst
    u_arvalid = 2'b01;
    m_arready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    u_arvalid = 2'b00;
    m_arready = 1'b0;
    u_rready  = 2'b11;
    m_rvalid  = 1'b1;
    tick();
    #1;
    chk("mid_outst", outstanding, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_rvld", u_rvalid, 0);
    chk("mid_rst_rrdy", m_rready, 0);
    chk("mid_rst_arvld", m_arvalid, 0);
    chk("mid_rst_err", rd_err, 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
